// File: rtl/stepper_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stepper_pkg
//  Description : Shared definitions for the four-coil stepper sequencer:
//                drive-mode encodings, the 8-entry half-step phase table,
//                FSM state encoding and phase arithmetic helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package stepper_pkg;

    // Drive-mode encodings as seen on the mode port (2'b11 behaves as full).
    localparam logic [1:0] MODE_WAVE = 2'b00;
    localparam logic [1:0] MODE_FULL = 2'b01;
    localparam logic [1:0] MODE_HALF = 2'b10;

    // Active-high {D,C,B,A} patterns. Even indices energise one coil,
    // odd indices energise two adjacent coils.
    localparam logic [3:0] PHASE_TABLE [8] = '{
        4'b0001, 4'b0011, 4'b0010, 4'b0110,
        4'b0100, 4'b1100, 4'b1000, 4'b1001
    };

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Collapse the reserved encoding onto full-step.
    function automatic logic [1:0] norm_mode(input logic [1:0] mode);
        case (mode)
            MODE_WAVE: norm_mode = MODE_WAVE;
            MODE_HALF: norm_mode = MODE_HALF;
            default:   norm_mode = MODE_FULL;
        endcase
    endfunction

    // Snap the rotor index onto the sub-table the mode walks:
    // wave uses even indices, full uses odd indices, half uses all.
    function automatic logic [2:0] align_phase(input logic [2:0] idx,
                                               input logic [1:0] mode);
        case (mode)
            MODE_WAVE: align_phase = {idx[2:1], 1'b0};
            MODE_HALF: align_phase = idx;
            default:   align_phase = {idx[2:1], 1'b1};
        endcase
    endfunction

    // Advance the index modulo 8 (3-bit wrap does the modulo).
    function automatic logic [2:0] next_phase(input logic [2:0] idx,
                                              input logic       dir,
                                              input logic [1:0] mode);
        logic [2:0] inc;
        inc = (mode == MODE_HALF) ? 3'd1 : 3'd2;
        next_phase = dir ? (idx + inc) : (idx - inc);
    endfunction

endpackage : stepper_pkg
`default_nettype wire

// File: rtl/stepper_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : stepper_prescaler
//  Description : Reloadable down-counter producing one tick every
//                (reload+1) enabled cycles.
//  Ports       : clk, rst     - clock, asynchronous active-high reset
//                load         - force count to reload (priority over en)
//                en           - count enable
//                reload       - value loaded on load and on each tick
//                tick         - high in the cycle the count sits at zero
//  Revision    : 1.0 - initial release
// ============================================================================
module stepper_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] reload,
    output logic             tick
);

    logic [DIV_W-1:0] r_count;

    assign tick = en && (r_count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= reload;
        end else if (en) begin
            if (r_count == '0) begin
                r_count <= reload;
            end else begin
                r_count <= r_count - DIV_W'(1);
            end
        end
    end

endmodule : stepper_prescaler
`default_nettype wire

// File: rtl/stepper_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stepper_seq_ctrl
//  Description : Four-coil stepper sequencer with wave / full / half-step
//                drive, direction, programmable step period and count,
//                start/busy/done handshake, abort and hold/release policy.
//  Ports       : clk, rst     - clock, asynchronous active-high reset
//                start        - move request, sampled only while idle
//                dir          - 1 forward, 0 reverse
//                mode         - 00 wave, 01 full, 10 half, 11 full
//                nsteps       - steps to execute
//                period       - clk cycles per step (0 behaves as 1)
//                abort        - stop a running move
//                coils        - {D,C,B,A} drive, polarity per COIL_ACTIVE_LOW
//                busy         - move in progress
//                done         - one-cycle pulse at move end
//                pos          - steps executed in current/last move
//  Revision    : 1.0 - initial release
// ============================================================================
module stepper_seq_ctrl
    import stepper_pkg::*;
#(
    parameter int DIV_W           = 16,
    parameter int CNT_W           = 12,
    parameter bit COIL_ACTIVE_LOW = 1'b1,
    parameter bit HOLD_EN         = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] nsteps,
    input  logic [DIV_W-1:0] period,
    input  logic             abort,
    output logic [3:0]       coils,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pos
);

    localparam logic [3:0] COILS_OFF = COIL_ACTIVE_LOW ? 4'b1111 : 4'b0000;

    // Map a phase index to the pin-level pattern.
    function automatic logic [3:0] drive(input logic [2:0] idx);
        drive = COIL_ACTIVE_LOW ? ~PHASE_TABLE[idx] : PHASE_TABLE[idx];
    endfunction

    state_t           r_state;
    logic [2:0]       r_phase;
    logic             r_dir;
    logic [1:0]       r_mode;
    logic [DIV_W-1:0] r_period_m1;
    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] r_pos;
    logic [3:0]       r_coils;
    logic             r_busy;
    logic             r_done;

    logic [1:0]       w_mode_in;
    logic [2:0]       w_aligned;
    logic [2:0]       w_next;
    logic [DIV_W-1:0] w_period_m1;
    logic [DIV_W-1:0] w_reload;
    logic             w_load;
    logic             w_run;
    logic             w_tick;

    assign w_mode_in   = norm_mode(mode);
    assign w_aligned   = align_phase(r_phase, w_mode_in);
    assign w_next      = next_phase(r_phase, r_dir, r_mode);
    // A zero period runs at one step per cycle.
    assign w_period_m1 = (period == '0) ? '0 : (period - DIV_W'(1));
    assign w_run       = (r_state == ST_RUN);
    assign w_load      = (r_state == ST_IDLE) && start && (nsteps != '0);
    // The latched period is not valid until after the accept edge, so the
    // first load takes the live port value.
    assign w_reload    = w_run ? r_period_m1 : w_period_m1;

    stepper_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .load   (w_load),
        .en     (w_run),
        .reload (w_reload),
        .tick   (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_phase     <= 3'd0;
            r_dir       <= 1'b0;
            r_mode      <= MODE_WAVE;
            r_period_m1 <= '0;
            r_remaining <= '0;
            r_pos       <= '0;
            r_coils     <= COILS_OFF;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // The final pattern of a move is shown for one cycle
                    // (alongside done) before release.
                    if (!HOLD_EN) begin
                        r_coils <= COILS_OFF;
                    end
                    if (start) begin
                        r_dir       <= dir;
                        r_mode      <= w_mode_in;
                        r_period_m1 <= w_period_m1;
                        r_remaining <= nsteps;
                        r_pos       <= '0;
                        if (nsteps == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_phase <= w_aligned;
                            r_coils <= drive(w_aligned);
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // Abort beats a coincident tick: no step is taken.
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_tick) begin
                        r_phase     <= w_next;
                        r_coils     <= drive(w_next);
                        r_pos       <= r_pos + CNT_W'(1);
                        r_remaining <= r_remaining - CNT_W'(1);
                        if (r_remaining == CNT_W'(1)) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign coils = r_coils;
    assign busy  = r_busy;
    assign done  = r_done;
    assign pos   = r_pos;

endmodule : stepper_seq_ctrl
`default_nettype wire

// File: tb/tb_stepper_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stepper_seq_ctrl
//  Description : Directed, table-driven bench for stepper_seq_ctrl with
//                default parameters (active-low coils, release after move).
//                Times below are counted in clock edges after the start
//                acceptance edge T; outputs are sampled 1ns after an edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stepper_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        dir;
    logic [1:0]  mode;
    logic [11:0] nsteps;
    logic [15:0] period;
    logic        abort;
    logic [3:0]  coils;
    logic        busy;
    logic        done;
    logic [11:0] pos;

    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    stepper_seq_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .dir    (dir),
        .mode   (mode),
        .nsteps (nsteps),
        .period (period),
        .abort  (abort),
        .coils  (coils),
        .busy   (busy),
        .done   (done),
        .pos    (pos)
    );

    always #5 clk = ~clk;

    // done is held for a whole cycle, so each pulse is seen exactly once here.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    typedef struct {
        logic [1:0]  mode;
        logic        dir;
        logic [11:0] nsteps;
        logic [15:0] period;
        logic [3:0]  first;   // aligned pattern after accept edge
        logic [3:0]  last;    // pattern shown with done
        int          cycles;  // edges from T to done
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present a request for one edge; returns just after the accept edge T.
    task automatic do_start(input logic [1:0] m, input logic d,
                            input logic [11:0] n, input logic [15:0] p);
        mode   = m;
        dir    = d;
        nsteps = n;
        period = p;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    int base;
    int cyc;

    initial begin
        // Phase walk (active-low patterns): 0:1110 1:1100 2:1101 3:1001
        // 4:1011 5:0011 6:0111 7:0110
        vecs[0] = '{2'b00, 1'b0, 12'd3, 16'd2, 4'b1011, 4'b0111, 6};  // 5->4,2,0,6
        vecs[1] = '{2'b01, 1'b1, 12'd2, 16'd1, 4'b0110, 4'b1001, 2};  // 6->7,1,3
        vecs[2] = '{2'b10, 1'b1, 12'd5, 16'd2, 4'b1001, 4'b1110, 10}; // 3..0
        vecs[3] = '{2'b11, 1'b0, 12'd1, 16'd5, 4'b1100, 4'b0110, 5};  // 0->1,7
        vecs[4] = '{2'b00, 1'b1, 12'd4, 16'd1, 4'b0111, 4'b0111, 4};  // 7->6..6
        vecs[5] = '{2'b10, 1'b0, 12'd2, 16'd0, 4'b0111, 4'b1011, 2};  // 6,5,4

        rst = 1'b1; start = 1'b0; dir = 1'b0; mode = 2'b00;
        nsteps = '0; period = '0; abort = 1'b0;
        tick();
        tick();
        chk("rst_coils", 32'(coils), 32'hF);
        chk("rst_busy",  32'(busy),  32'h0);
        chk("rst_done",  32'(done),  32'h0);
        chk("rst_pos",   32'(pos),   32'h0);
        rst = 1'b0;
        tick();

        // Full, forward, 4 steps every 3 cycles from phase 0.
        base = done_cnt;
        do_start(2'b01, 1'b1, 12'd4, 16'd3);
        chk("full_T0_coils", 32'(coils), 32'hC);
        chk("full_T0_busy",  32'(busy),  32'h1);
        tick();
        chk("full_T1_coils", 32'(coils), 32'hC);
        tick(); tick();
        chk("full_T3_coils", 32'(coils), 32'h9);
        chk("full_T3_pos",   32'(pos),   32'h1);
        repeat (3) tick();
        chk("full_T6_coils", 32'(coils), 32'h3);
        repeat (3) tick();
        chk("full_T9_coils", 32'(coils), 32'h6);
        chk("full_T9_busy",  32'(busy),  32'h1);
        repeat (3) tick();
        chk("full_T12_coils", 32'(coils), 32'hC);
        chk("full_T12_done",  32'(done),  32'h1);
        chk("full_T12_busy",  32'(busy),  32'h0);
        chk("full_T12_pos",   32'(pos),   32'h4);
        tick();
        chk("full_T13_coils", 32'(coils), 32'hF);
        chk("full_T13_done",  32'(done),  32'h0);
        chk("full_done_once", 32'(done_cnt - base), 32'h1);

        // Half, reverse, 3 steps at period 0 from phase 0: 0,7,6,5.
        do_reset();
        base = done_cnt;
        do_start(2'b10, 1'b0, 12'd3, 16'd0);
        chk("half_T0_coils", 32'(coils), 32'hE);
        tick();
        chk("half_T1_coils", 32'(coils), 32'h6);
        tick();
        chk("half_T2_coils", 32'(coils), 32'h7);
        tick();
        chk("half_T3_coils", 32'(coils), 32'h3);
        chk("half_T3_done",  32'(done),  32'h1);
        chk("half_T3_pos",   32'(pos),   32'h3);
        tick();
        chk("half_release",  32'(coils), 32'hF);
        chk("half_done_once", 32'(done_cnt - base), 32'h1);

        // Chained moves; rotor index carries over between entries.
        for (int i = 0; i < 6; i++) begin
            base = done_cnt;
            do_start(vecs[i].mode, vecs[i].dir, vecs[i].nsteps, vecs[i].period);
            chk($sformatf("vec%0d_first", i), 32'(coils), 32'(vecs[i].first));
            cyc = 0;
            do begin
                tick();
                cyc++;
            end while (done !== 1'b1 && cyc < 200);
            chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].cycles));
            chk($sformatf("vec%0d_last", i), 32'(coils), 32'(vecs[i].last));
            chk($sformatf("vec%0d_pos", i), 32'(pos), 32'(vecs[i].nsteps));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'h0);
            tick();
            chk($sformatf("vec%0d_release", i), 32'(coils), 32'hF);
            chk($sformatf("vec%0d_done_once", i), 32'(done_cnt - base), 32'h1);
        end

        // Abort coincident with the 2nd tick (phase 4 -> aligned 5 -> 7).
        base = done_cnt;
        do_start(2'b01, 1'b1, 12'd10, 16'd4);
        chk("abort_T0_coils", 32'(coils), 32'h3);
        repeat (4) tick();
        chk("abort_T4_coils", 32'(coils), 32'h6);
        chk("abort_T4_pos",   32'(pos),   32'h1);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_T8_done",  32'(done),  32'h1);
        chk("abort_T8_busy",  32'(busy),  32'h0);
        chk("abort_T8_pos",   32'(pos),   32'h1);
        chk("abort_T8_coils", 32'(coils), 32'h6);
        tick();
        chk("abort_T9_coils", 32'(coils), 32'hF);
        chk("abort_T9_done",  32'(done),  32'h0);
        chk("abort_done_once", 32'(done_cnt - base), 32'h1);

        // Abort while idle does nothing.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_busy", 32'(busy), 32'h0);
        chk("idle_abort_done", 32'(done), 32'h0);

        // Zero-step request: done only.
        base = done_cnt;
        do_start(2'b00, 1'b1, 12'd0, 16'd5);
        chk("zero_done",  32'(done),  32'h1);
        chk("zero_busy",  32'(busy),  32'h0);
        chk("zero_coils", 32'(coils), 32'hF);
        tick();
        chk("zero_done_T1",  32'(done),  32'h0);
        chk("zero_busy_T1",  32'(busy),  32'h0);
        chk("zero_coils_T1", 32'(coils), 32'hF);
        chk("zero_done_once", 32'(done_cnt - base), 32'h1);

        // start during a run is ignored (phase 7: 7,1,3,5).
        base = done_cnt;
        do_start(2'b01, 1'b1, 12'd3, 16'd2);
        chk("busy_start_T0", 32'(coils), 32'h6);
        tick(); tick();
        chk("busy_start_T2", 32'(coils), 32'hC);
        mode = 2'b10; dir = 1'b0; nsteps = 12'd9; period = 16'd1; start = 1'b1;
        tick(); tick();
        start = 1'b0;
        chk("busy_start_T4", 32'(coils), 32'h9);
        tick();
        chk("busy_start_T5_busy", 32'(busy), 32'h1);
        tick();
        chk("busy_start_T6_coils", 32'(coils), 32'h3);
        chk("busy_start_T6_done",  32'(done),  32'h1);
        chk("busy_start_T6_pos",   32'(pos),   32'h3);
        tick();
        chk("busy_start_release",  32'(coils), 32'hF);
        chk("busy_start_done_once", 32'(done_cnt - base), 32'h1);

        // Asynchronous reset in the middle of a 10-step move.
        base = done_cnt;
        do_start(2'b01, 1'b1, 12'd10, 16'd2);
        repeat (5) tick();
        chk("mrst_pre_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        chk("mrst_coils", 32'(coils), 32'hF);
        chk("mrst_busy",  32'(busy),  32'h0);
        chk("mrst_pos",   32'(pos),   32'h0);
        chk("mrst_done",  32'(done),  32'h0);
        tick();
        rst = 1'b0;
        repeat (6) tick();
        chk("mrst_no_done", 32'(done_cnt - base), 32'h0);
        chk("mrst_idle",    32'(busy),  32'h0);
        chk("mrst_off",     32'(coils), 32'hF);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule : tb_stepper_seq_ctrl
`default_nettype wire
